// File: rtl/acq_pkg.sv
// Shared types and constants for the acquisition scheduler: FSM states,
// per-sensor command templates and command/result field positions.
package acq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPTURE,
        ST_GAP
    } state_t;

    localparam int MODE_SLOW_BIT = 31;
    localparam int MODE_FAST_BIT = 30;
    localparam int SEL_MSB       = 29;
    localparam int SEL_LSB       = 27;
    localparam int DONE_BIT      = 31;

    localparam logic [15:0] ABORT_DATA = 16'hFFFF;

    // Sensor select lives in bits 29:27; bits 26:0 carry per-sensor settings.
    localparam logic [31:0] CMD_TEMPLATE [8] = '{
        32'h0000_0000,
        32'h0800_0101,
        32'h1000_0202,
        32'h1800_0303,
        32'h2000_0404,
        32'h2800_0505,
        32'h3000_0606,
        32'h3800_0707
    };

endpackage

// File: rtl/acq_watchdog.sv
// Saturating cycle counter with synchronous clear; flags expiry once the
// count reaches CYCLES-1 and holds there instead of wrapping.
module acq_watchdog
    import acq_pkg::*;
#(
    parameter int CYCLES = 4096
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int            CW   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [CW-1:0] r_count;

    // NOTE: sequential state is written only with <= so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_expired = (r_count == LAST);

endmodule

// File: rtl/acq_scheduler.sv
// Sweeps the latched sensor mask in ascending order, issuing one command per
// sensor, capturing the result (or aborting on watchdog) and idling between.
module acq_scheduler
    import acq_pkg::*;
#(
    parameter int GAP_CYCLES      = 10,
    parameter int WATCHDOG_CYCLES = 4096
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic        i_start,
    input  logic [7:0]  i_sensor_mask,
    input  logic        i_fast_mode,
    output logic [31:0] o_acq_command,
    input  logic [31:0] i_acq_result,
    output logic        o_result_wr_en,
    output logic [2:0]  o_result_idx,
    output logic [15:0] o_result_data,
    output logic        o_busy,
    output logic        o_sweep_done,
    output logic        o_timeout_err
);

    localparam int            GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic [7:0]    r_mask;
    logic          r_fast;
    logic [2:0]    r_idx;
    logic [GW-1:0] r_gap_cnt;
    logic [2:0]    r_result_idx;
    logic [15:0]   r_result_data;
    logic          r_timeout_err;

    logic          w_found;
    logic [2:0]    w_next_idx;
    logic          w_done;
    logic          w_wd_expired;
    logic          w_start_ok;
    logic [31:0]   w_cmd;
    logic          w_unused;

    assign w_done     = i_acq_result[DONE_BIT];
    assign w_start_ok = (r_state == ST_IDLE) && i_en && i_start;
    assign w_unused   = ^{i_acq_result[30:16], r_mask[0]};

    acq_watchdog #(
        .CYCLES (WATCHDOG_CYCLES)
    ) u_watchdog (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (r_state != ST_WAIT),
        .i_enable  (r_state == ST_WAIT),
        .o_expired (w_wd_expired)
    );

    // Descending scan so the lowest qualifying index is the one left standing.
    always_comb begin
        w_found    = 1'b0;
        w_next_idx = '0;
        for (int i = 7; i >= 1; i--) begin
            if (r_mask[i] && (3'(i) > r_idx)) begin
                w_found    = 1'b1;
                w_next_idx = 3'(i);
            end
        end
    end

    // NOTE: every signal gets a default before the case so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        w_next_state   = r_state;
        w_cmd          = CMD_TEMPLATE[r_idx];
        w_cmd[SEL_MSB:SEL_LSB] = r_idx;
        w_cmd[MODE_SLOW_BIT]   = ~r_fast;
        w_cmd[MODE_FAST_BIT]   = r_fast;
        o_acq_command  = '0;
        o_result_wr_en = 1'b0;
        o_sweep_done   = 1'b0;

        case (r_state)
            ST_IDLE:    if (i_start) w_next_state = ST_SELECT;
            ST_SELECT: begin
                w_next_state = w_found ? ST_ISSUE : ST_IDLE;
                o_sweep_done = !w_found && i_en;
            end
            ST_ISSUE: begin
                o_acq_command = w_cmd;
                w_next_state  = ST_WAIT;
            end
            ST_WAIT: begin
                o_acq_command = w_cmd;
                if (w_done || w_wd_expired) w_next_state = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                o_result_wr_en = 1'b1;
                w_next_state   = ST_GAP;
            end
            ST_GAP:     if (r_gap_cnt == GAP_LAST) w_next_state = ST_SELECT;
            default:    w_next_state = ST_IDLE;
        endcase

        if (!i_en) w_next_state = ST_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_mask        <= '0;
            r_fast        <= 1'b0;
            r_idx         <= '0;
            r_gap_cnt     <= '0;
            r_result_idx  <= '0;
            r_result_data <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_gap_cnt <= (r_state == ST_GAP) ? r_gap_cnt + GW'(1) : '0;

            if (w_start_ok) begin
                r_mask        <= i_sensor_mask;
                r_fast        <= i_fast_mode;
                r_idx         <= '0;
                r_timeout_err <= 1'b0;
            end

            if (r_state == ST_SELECT && w_found) r_idx <= w_next_idx;

            // Completion is checked first so a same-cycle expiry never aborts.
            if (r_state == ST_WAIT && w_next_state == ST_CAPTURE) begin
                r_result_idx <= r_idx;
                if (w_done) begin
                    r_result_data <= i_acq_result[15:0];
                end else begin
                    r_result_data <= ABORT_DATA;
                    r_timeout_err <= 1'b1;
                end
            end
        end
    end

    assign o_result_idx  = r_result_idx;
    assign o_result_data = r_result_data;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_acq_scheduler.sv
// Directed bench: two scheduler instances (default watchdog and a 16-cycle
// watchdog) share stimulus; a small IP model answers each command.
module tb_acq_scheduler;

    localparam int GAP = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  mask = '0;
    logic        fast = 1'b0;

    logic [31:0] cmd0, cmd1;
    logic [31:0] res0 = '0, res1 = '0;
    logic        wr0, wr1, busy0, busy1, sd0, sd1, to0, to1;
    logic [2:0]  idx0, idx1;
    logic [15:0] data0, data1;

    int          ip_latency = 0;
    logic [15:0] ip_data = '0;
    int          ip_cnt0 = 0, ip_cnt1 = 0;

    int          n_checks = 0;
    int          n_pass = 0;

    typedef struct {
        logic [7:0]      mask;
        logic            fast;
        int              lat;
        logic [15:0]     din;
        bit              sel;
        int              restart_at;
        int              exp_n;
        logic [6:0][2:0] exp_seq;
        logic [15:0]     exp_data;
        logic            exp_to;
        int              exp_done;
        logic [31:0]     exp_first;
    } vec_t;

    vec_t rows [7];

    always #5 clk = ~clk;

    acq_scheduler #(.GAP_CYCLES(GAP), .WATCHDOG_CYCLES(4096)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_start(start),
        .i_sensor_mask(mask), .i_fast_mode(fast), .o_acq_command(cmd0),
        .i_acq_result(res0), .o_result_wr_en(wr0), .o_result_idx(idx0),
        .o_result_data(data0), .o_busy(busy0), .o_sweep_done(sd0),
        .o_timeout_err(to0)
    );

    acq_scheduler #(.GAP_CYCLES(GAP), .WATCHDOG_CYCLES(16)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_start(start),
        .i_sensor_mask(mask), .i_fast_mode(fast), .o_acq_command(cmd1),
        .i_acq_result(res1), .o_result_wr_en(wr1), .o_result_idx(idx1),
        .o_result_data(data1), .o_busy(busy1), .o_sweep_done(sd1),
        .o_timeout_err(to1)
    );

    // IP model: done (bit31) with data once a command has been held ip_latency
    // negedges; latency 0 means it never completes.
    function automatic logic [31:0] ip_resp(input int cnt);
        if (ip_latency != 0 && cnt >= ip_latency) return {1'b1, 15'd0, ip_data};
        return 32'd0;
    endfunction

    always @(negedge clk) begin
        ip_cnt0 = (cmd0 == 32'd0) ? 0 : ip_cnt0 + 1;
        ip_cnt1 = (cmd1 == 32'd0) ? 0 : ip_cnt1 + 1;
        res0 = ip_resp(ip_cnt0);
        res1 = ip_resp(ip_cnt1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic run_sweep(input string tag, input vec_t v);
        int          cyc = 0, n_res = 0, n_cmd = 0, zero_run = 0, k = 0;
        bit          done = 0;
        logic [31:0] cmd, prev_cmd = '0;
        logic        wr, sd;
        logic [2:0]  ridx;
        logic [15:0] rdata;

        mask = v.mask; fast = v.fast; ip_latency = v.lat; ip_data = v.din;
        start = 1'b1;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (v.restart_at == cyc) begin
                start = 1'b1;
                mask  = 8'hFE;
            end
            cmd   = v.sel ? cmd1  : cmd0;
            wr    = v.sel ? wr1   : wr0;
            sd    = v.sel ? sd1   : sd0;
            ridx  = v.sel ? idx1  : idx0;
            rdata = v.sel ? data1 : data0;
            if (cmd != 32'd0 && cmd != prev_cmd) begin
                if (n_cmd == 0) check({tag, " first_cmd"}, cmd, v.exp_first);
                else check({tag, " gap_zero_cycles"}, 32'(zero_run), 32'(GAP + 2));
                check({tag, " cmd_mode"}, 32'(cmd[31:30]), 32'({~v.fast, v.fast}));
                if (n_cmd < 7) check({tag, " cmd_sel"}, 32'(cmd[29:27]), 32'(v.exp_seq[n_cmd]));
                n_cmd++;
            end
            zero_run = (cmd == 32'd0) ? zero_run + 1 : 0;
            prev_cmd = cmd;
            if (wr) begin
                if (n_res < 7) check({tag, " res_idx"}, 32'(ridx), 32'(v.exp_seq[n_res]));
                check({tag, " res_data"}, 32'(rdata), 32'(v.exp_data));
                n_res++;
            end
            if (sd) begin
                check({tag, " done_cycle"}, 32'(cyc), 32'(v.exp_done));
                done = 1;
            end
        end
        check({tag, " sweep_done_seen"}, 32'(done), 32'd1);
        check({tag, " n_results"}, 32'(n_res), 32'(v.exp_n));
        check({tag, " n_cmds"}, 32'(n_cmd), 32'(v.exp_n));
        check({tag, " timeout_err"}, 32'(v.sel ? to1 : to0), 32'(v.exp_to));
        repeat (5) @(negedge clk);
        check({tag, " idle_busy"}, 32'(v.sel ? busy1 : busy0), 32'd0);
        check({tag, " timeout_sticky"}, 32'(v.sel ? to1 : to0), 32'(v.exp_to));
        while ((busy0 || busy1) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check({tag, " both_idle"}, 32'(busy0 | busy1), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy"}, 32'(busy0), 32'd0);
        check({tag, " cmd"}, cmd0, 32'd0);
        check({tag, " wr_en"}, 32'(wr0), 32'd0);
        check({tag, " idx"}, 32'(idx0), 32'd0);
        check({tag, " data"}, 32'(data0), 32'd0);
        check({tag, " sweep_done"}, 32'(sd0), 32'd0);
        check({tag, " timeout"}, 32'(to0), 32'd0);
        check({tag, " timeout_wd16"}, 32'(to1), 32'd0);
    endtask

    initial begin
        int   n_wr, n_sd, c3;
        bit   dropped, got;
        vec_t v_drop, v_restart, v_zero;

        //             mask   fast lat din       sel rst n  seq                                              data      to  done first
        rows[0] = '{8'h02, 1'b0, 20, 16'h0001, 1'b0, 0, 1, {18'd0, 3'd1}, 16'h0001, 1'b0, 33, 32'h8800_0101};
        rows[1] = '{8'hFE, 1'b1, 5, 16'hA5A5, 1'b0, 0, 7,
                    {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1}, 16'hA5A5, 1'b0, 120, 32'h4800_0101};
        rows[2] = '{8'h01, 1'b1, 3, 16'h1111, 1'b0, 0, 0, 21'd0, 16'h0000, 1'b0, 1, 32'h0000_0000};
        rows[3] = '{8'h20, 1'b0, 0, 16'h2222, 1'b1, 0, 1, {18'd0, 3'd5}, 16'hFFFF, 1'b1, 30, 32'hA800_0505};
        rows[4] = '{8'h90, 1'b1, 2, 16'h1234, 1'b1, 0, 2, {15'd0, 3'd7, 3'd4}, 16'h1234, 1'b0, 29, 32'h6000_0404};
        rows[5] = '{8'h08, 1'b0, 17, 16'hBEEF, 1'b1, 0, 1, {18'd0, 3'd3}, 16'hBEEF, 1'b0, 30, 32'h9800_0303};
        rows[6] = '{8'h40, 1'b1, 0, 16'h3333, 1'b1, 0, 1, {18'd0, 3'd6}, 16'hFFFF, 1'b1, 30, 32'h7000_0606};
        v_drop    = '{8'h0A, 1'b1, 5, 16'h0C0C, 1'b0, 0, 2, {15'd0, 3'd3, 3'd1}, 16'h0C0C, 1'b0, 35, 32'h4800_0101};
        v_restart = '{8'h02, 1'b0, 20, 16'h0001, 1'b0, 10, 1, {18'd0, 3'd1}, 16'h0001, 1'b0, 33, 32'h8800_0101};
        v_zero    = '{8'h00, 1'b0, 3, 16'h7777, 1'b0, 0, 0, 21'd0, 16'h0000, 1'b0, 1, 32'h0000_0000};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_sweep($sformatf("row%0d", i), rows[i]);

        // Disable alone must not clear a sticky timeout; reset must.
        en = 1'b0;
        repeat (3) @(negedge clk);
        check("en_low timeout_retained", 32'(to1), 32'd1);
        en = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst timeout_cleared", 32'(to1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Drop enable during the second WAIT cycle of sensor 3.
        mask = 8'h0A; fast = 1'b1; ip_latency = 5; ip_data = 16'h0C0C;
        start = 1'b1;
        n_wr = 0; c3 = 0; dropped = 0;
        for (int k = 0; k < 300 && !dropped; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (wr0) n_wr++;
            if (cmd0 != 32'd0 && cmd0[29:27] == 3'd3) begin
                c3++;
                if (c3 == 3) begin
                    en = 1'b0;
                    dropped = 1;
                end
            end
        end
        check("drop reached_idx3", 32'(dropped), 32'd1);
        check("drop prior_results", 32'(n_wr), 32'd1);
        @(negedge clk);
        check("drop cmd", cmd0, 32'd0);
        check("drop busy", 32'(busy0), 32'd0);
        n_wr = 0; n_sd = 0;
        repeat (20) begin
            @(negedge clk);
            n_wr += int'(wr0);
            n_sd += int'(sd0);
        end
        check("drop no_wr_en", 32'(n_wr), 32'd0);
        check("drop no_sweep_done", 32'(n_sd), 32'd0);
        en = 1'b1;
        run_sweep("after_drop", v_drop);

        // Asynchronous reset in the middle of GAP.
        mask = 8'h04; fast = 1'b1; ip_latency = 3; ip_data = 16'h5A5A;
        start = 1'b1;
        got = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (wr0) got = 1;
        end
        check("gap result_seen", 32'(got), 32'd1);
        check("gap result_idx", 32'(idx0), 32'd2);
        check("gap result_data", 32'(data0), 32'h5A5A);
        repeat (3) @(negedge clk);
        check("gap busy_before_rst", 32'(busy0), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("gap_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_sweep("restart_ignored", v_restart);
        run_sweep("mask_zero", v_zero);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/acq_scheduler.md
ACQ_SCHEDULER -- requirements
Module: acq_scheduler

Interface
REQ-001 Parameter GAP_CYCLES, default 10: cycles AcqCommand is held at 0 between measurements.
REQ-002 Parameter WATCHDOG_CYCLES, default 4096: maximum cycles to wait for a result before abort.
REQ-003 Clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Rst_n  in  1  asynchronous, active-low reset.
REQ-005 En  in  1  block enable; low forces IDLE with AcqCommand=0.
REQ-006 Start  in  1  one-cycle pulse; begins a sweep when IDLE.
REQ-007 SensorMask  in  8  sensor n measured when bit n=1; bit 0 ignored (no sensor 0).
REQ-008 FastMode  in  1  1=fast (bit30 set), 0=slow (bit31 set) in every issued command.
REQ-009 AcqCommand  out  32  command driven to the acquisition IP.
REQ-010 AcqResult  in  32  acquisition IP result word; bit31=measurement complete, bits 15:0=data.
REQ-011 ResultWrEn  out  1  one-cycle strobe; ResultIdx/ResultData valid.
REQ-012 ResultIdx  out  3  sensor index of the current result.
REQ-013 ResultData  out  16  AcqResult[15:0] captured on completion; 16'hFFFF on watchdog abort.
REQ-014 Busy  out  1  high in every state except IDLE.
REQ-015 SweepDone  out  1  one-cycle pulse after the last enabled sensor's GAP completes.
REQ-016 TimeoutErr  out  1  sticky; set on any watchdog abort, cleared by Start.

Function
REQ-017 FSM states: IDLE, SELECT, ISSUE, WAIT, CAPTURE, GAP.
REQ-018 IDLE->SELECT on Start=1 and En=1; SensorMask and FastMode are latched on that edge.
REQ-019 SELECT: pick the lowest latched-mask index above the current index (starting from 1); none left -> IDLE with SweepDone pulse; 1 cycle.
REQ-020 ISSUE: AcqCommand = CMD_TEMPLATE[idx] with bits 31:30 replaced by {~FastMode, FastMode}; ISSUE->WAIT next cycle; AcqCommand is held through WAIT.
REQ-021 WAIT: watchdog counter starts at 0 and increments each cycle; AcqResult[31]=1 -> CAPTURE; counter reaching WATCHDOG_CYCLES-1 with no completion -> CAPTURE with abort flag set.
REQ-022 CAPTURE: ResultWrEn=1 for exactly one cycle; ResultIdx=idx; ResultData per REQ-013; AcqCommand=0; next state GAP.
REQ-023 GAP: AcqCommand=0 for GAP_CYCLES cycles, then SELECT; guarantees the IP returns to idle before the next command.
REQ-024 Sweep order is strictly ascending index; each masked sensor is measured exactly once per Start.
REQ-025 Start while Busy is ignored.
REQ-026 Latched SensorMask all zero (bits 7:1): SELECT->IDLE; SweepDone pulses; no ResultWrEn.
REQ-027 En deasserted in any state: next cycle state=IDLE, AcqCommand=0, no ResultWrEn, no SweepDone; TimeoutErr is retained.
REQ-028 Completion and watchdog expiry in the same cycle: completion wins (no abort, TimeoutErr unchanged).
REQ-029 Watchdog counter width is clog2(WATCHDOG_CYCLES); the counter never wraps.

Reset
REQ-030 Rst_n=0 asynchronously forces: state IDLE; AcqCommand=0; ResultWrEn=0; ResultIdx=0; ResultData=0; Busy=0; SweepDone=0; TimeoutErr=0; latched mask/mode=0; counters=0.
REQ-031 Reset mid-sweep discards the sweep; the first Start after release begins a sweep at the lowest masked index.

Structure
REQ-032 Shared package acq_pkg holds: state enum; CMD_TEMPLATE[8] 32-bit constants (sensor select in bits 29:27, per-sensor fields in bits 26:0); field position constants for the mode, sensor-select and done bits.
REQ-033 One sub-module: acq_watchdog (clear/enable counter with expiry flag); everything else is flat.

Verification
REQ-034 Mask=8'b0000_0010, slow, IP returns done after 20 cycles with data 16'h0001 -> AcqCommand[31:27]=5'b10001; ResultWrEn once, ResultIdx=1, ResultData=16'h0001; SweepDone after 10 gap cycles.
REQ-035 Mask=8'b1111_1110, fast, each result returns after 5 cycles -> 7 ResultWrEn strobes in order idx 1..7; AcqCommand bit30=1 in each; AcqCommand=0 for 10 cycles between commands.
REQ-036 Mask=8'b0010_0000, WATCHDOG_CYCLES=16, IP never completes -> ResultWrEn after 16 WAIT cycles with ResultData=16'hFFFF; TimeoutErr=1 until the next Start.
REQ-037 En dropped during WAIT of idx 3 -> AcqCommand=0 next cycle; no ResultWrEn or SweepDone; a new Start restarts at idx 1.
REQ-038 Rst_n pulsed low mid-GAP -> all outputs 0 immediately; Start pulse while Busy is ignored; mask=0 -> SweepDone only.
